// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the BCD digit accumulator
//   state_t   : controller states (collecting, converting, result held)
//   BCD_MAX   : largest legal BCD digit value
//   bin_width : minimum binary width that holds 10^digits - 1
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int bin_width(input int digits);
        longint unsigned v;
        int              w;
        v = 1;
        w = 0;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        v = v - 1;
        for (int i = 0; i < 64; i++) begin
            if (v != 0) begin
                v = v >> 1;
                w = w + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// rtl/bcd_mac_step.sv - combinational acc*10 + digit for the conversion datapath
//   acc_in  : running binary accumulator
//   digit   : next BCD nibble (0..9)
//   acc_out : acc_in*10 + digit, truncated to BIN_W
module bcd_mac_step #(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_out
);

    logic [BIN_W-1:0] w_times8;
    logic [BIN_W-1:0] w_times2;

    // Multiply by ten as x*8 + x*2 so no multiplier is inferred.
    assign w_times8 = acc_in << 3;
    assign w_times2 = acc_in << 1;
    assign acc_out  = w_times8 + w_times2 + BIN_W'(digit);

endmodule

// File: rtl/bcd_digit_accumulator.sv
// rtl/bcd_digit_accumulator.sv - collects BCD digits MSD first and converts them to binary
//   clk, reset (async, active high)
//   digit_in/digit_err/digit_stb : filtered digit stream from the validity filter
//   enter : start conversion, clear : discard entry and sticky flags
//   bcd_out/count : packed entry and number of digits held
//   bin_out/bin_valid/busy : conversion result and status
//   err_flag/overflow : sticky flags, cleared only by clear or reset
module bcd_digit_accumulator
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    parameter  int BIN_W  = 14,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            digit_in,
    input  logic                  digit_err,
    input  logic                  digit_stb,
    input  logic                  enter,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [CNT_W-1:0]      count,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  bin_valid,
    output logic                  busy,
    output logic                  err_flag,
    output logic                  overflow
);

    localparam int                BCD_W     = 4 * DIGITS;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(DIGITS - 1);

    state_t             r_state;
    state_t             w_next_state;

    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_count;
    logic [BIN_W-1:0]   r_bin;
    logic               r_bin_valid;
    logic               r_err;
    logic               r_ovf;
    logic [BCD_W-1:0]   r_work;
    logic [BIN_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_step;

    logic               w_accept;
    logic               w_set_err;
    logic               w_set_ovf;
    logic               w_start;
    logic               w_step;
    logic               w_finish;
    logic               w_new_entry;

    logic [BCD_W+3:0]   w_bcd_shift_wide;
    logic [BCD_W+3:0]   w_bcd_first_wide;
    logic [BCD_W+3:0]   w_work_shift_wide;
    logic [3:0]         w_nibble;
    logic [BIN_W-1:0]   w_acc_next;

    // Widened concatenations keep the slices legal even when DIGITS is 1.
    assign w_bcd_shift_wide  = {r_bcd, digit_in};
    assign w_bcd_first_wide  = {{BCD_W{1'b0}}, digit_in};
    assign w_work_shift_wide = {r_work, 4'h0};
    assign w_nibble          = r_work[BCD_W-1 -: 4];

    bcd_mac_step #(
        .BIN_W   (BIN_W)
    ) u_mac (
        .acc_in  (r_acc),
        .digit   (w_nibble),
        .acc_out (w_acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority: clear > enter > digit_stb; inputs other than clear are ignored while converting.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_set_err    = 1'b0;
        w_set_ovf    = 1'b0;
        w_start      = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_new_entry  = 1'b0;
        if (clear) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enter) begin
                        w_start      = 1'b1;
                        w_next_state = ST_CONVERT;
                    end else if (digit_stb) begin
                        if (digit_err) begin
                            w_set_err = 1'b1;
                        end else if (r_count < CNT_FULL) begin
                            w_accept = 1'b1;
                        end else begin
                            w_set_ovf = 1'b1;
                        end
                    end
                end
                ST_CONVERT: begin
                    w_step = 1'b1;
                    if (r_step == STEP_LAST) begin
                        w_finish     = 1'b1;
                        w_next_state = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (digit_stb) begin
                        if (digit_err) begin
                            w_set_err = 1'b1;
                        end else begin
                            w_new_entry  = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd       <= '0;
            r_count     <= '0;
            r_bin       <= '0;
            r_bin_valid <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_work      <= '0;
            r_acc       <= '0;
            r_step      <= '0;
        end else if (clear) begin
            r_bcd       <= '0;
            r_count     <= '0;
            r_bin       <= '0;
            r_bin_valid <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_work      <= '0;
            r_acc       <= '0;
            r_step      <= '0;
        end else begin
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_accept) begin
                r_bcd   <= w_bcd_shift_wide[BCD_W-1:0];
                r_count <= r_count + 1'b1;
            end
            if (w_new_entry) begin
                r_bcd       <= w_bcd_first_wide[BCD_W-1:0];
                r_count     <= CNT_W'(1);
                r_bin       <= '0;
                r_bin_valid <= 1'b0;
            end
            if (w_start) begin
                r_work <= r_bcd;
                r_acc  <= '0;
                r_step <= '0;
            end
            if (w_step) begin
                r_work <= w_work_shift_wide[BCD_W-1:0];
                r_acc  <= w_acc_next;
                r_step <= r_step + 1'b1;
            end
            if (w_finish) begin
                r_bin       <= w_acc_next;
                r_bin_valid <= 1'b1;
            end
        end
    end

    assign bcd_out   = r_bcd;
    assign count     = r_count;
    assign bin_out   = r_bin;
    assign bin_valid = r_bin_valid;
    assign busy      = (r_state == ST_CONVERT);
    assign err_flag  = r_err;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// tb/tb_bcd_digit_accumulator.sv - scoreboard bench for bcd_digit_accumulator
module tb_bcd_digit_accumulator;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  digit_in = 4'h0;
    logic        digit_err = 1'b0;
    logic        digit_stb = 1'b0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] bcd_out;
    logic [2:0]  count;
    logic [13:0] bin_out;
    logic        bin_valid;
    logic        busy;
    logic        err_flag;
    logic        overflow;

    typedef struct {
        int bin;
        int bcd;
        int cnt;
        bit err;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int m_digits[$];
    bit m_err;
    bit m_ovf;
    bit m_done;

    bcd_digit_accumulator #(
        .DIGITS    (DIGITS),
        .BIN_W     (BIN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digit_in  (digit_in),
        .digit_err (digit_err),
        .digit_stb (digit_stb),
        .enter     (enter),
        .clear     (clear),
        .bcd_out   (bcd_out),
        .count     (count),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .busy      (busy),
        .err_flag  (err_flag),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        return v;
    endfunction

    function automatic int m_bcd();
        int b = 0;
        foreach (m_digits[i]) b = b * 16 + m_digits[i];
        return b;
    endfunction

    task automatic m_reset();
        m_digits.delete();
        m_err  = 1'b0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " bcd_out"}, bcd_out, 0);
        check({name, " count"}, count, 0);
        check({name, " bin_out"}, bin_out, 0);
        check({name, " flags"}, {bin_valid, busy, err_flag, overflow}, 0);
    endtask

    task automatic strobe(input logic [3:0] d, input bit e);
        digit_in  = d;
        digit_err = e;
        digit_stb = 1'b1;
        @(posedge clk);
        #1;
        digit_stb = 1'b0;
        digit_err = 1'b0;
        if (e) begin
            m_err = 1'b1;
        end else if (m_done) begin
            m_digits.delete();
            m_digits.push_back(int'(d));
            m_done = 1'b0;
        end else if (m_digits.size() < DIGITS) begin
            m_digits.push_back(int'(d));
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_reset();
    endtask

    task automatic do_enter(input bit with_stb, input logic [3:0] d);
        exp_t e;
        enter = 1'b1;
        if (with_stb) begin
            digit_in  = d;
            digit_err = 1'b0;
            digit_stb = 1'b1;
        end
        e.bin = m_value();
        e.bcd = m_bcd();
        e.cnt = m_digits.size();
        e.err = m_err;
        e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        enter     = 1'b0;
        digit_stb = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (busy && cyc < 20) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        check({name, " busy cycles"}, cyc, DIGITS);
        check({name, " bin_valid"}, bin_valid, 1);
        m_done = 1'b1;
    endtask

    initial begin : monitor
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bin_valid && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got bin_out %0d expected no result", bin_out);
                end else begin
                    e = sb.pop_front();
                    check("result bin_out", bin_out, e.bin);
                    check("result bcd_out", bcd_out, e.bcd);
                    check("result count", count, e.cnt);
                    check("result err_flag", err_flag, e.err);
                    check("result overflow", overflow, e.ovf);
                end
            end
            prev = bin_valid;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        m_reset();
        #12;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        strobe(4'd1, 0); strobe(4'd2, 0); strobe(4'd3, 0); strobe(4'd4, 0);
        check("t1 bcd_out", bcd_out, 16'h1234);
        check("t1 count", count, 4);
        do_enter(0, 4'h0);
        wait_done("t1");

        do_clear();
        check_all_zero("clear after done");
        strobe(4'hB, 1); strobe(4'd7, 0);
        check("t2 err_flag", err_flag, 1);
        check("t2 count", count, 1);
        check("t2 bcd_out", bcd_out, 16'h0007);
        do_enter(0, 4'h0);
        wait_done("t2");

        do_clear();
        strobe(4'd9, 0); strobe(4'd9, 0); strobe(4'd9, 0); strobe(4'd9, 0);
        check("t3 overflow before", overflow, 0);
        strobe(4'd5, 0);
        check("t3 overflow", overflow, 1);
        check("t3 bcd_out", bcd_out, 16'h9999);
        check("t3 count", count, 4);
        do_enter(0, 4'h0);
        wait_done("t3");

        do_clear();
        do_enter(0, 4'h0);
        wait_done("t4");
        check("t4 bin_out", bin_out, 0);
        enter = 1'b1;
        @(posedge clk);
        #1;
        enter = 1'b0;
        check("t4 enter in done busy", busy, 0);
        check("t4 enter in done valid", bin_valid, 1);
        strobe(4'd3, 0);
        check("t4 new bin_valid", bin_valid, 0);
        check("t4 new count", count, 1);
        check("t4 new bcd_out", bcd_out, 16'h0003);

        do_clear();
        strobe(4'd5, 0); strobe(4'd6, 0);
        do_enter(0, 4'h0);
        @(posedge clk);
        #1;
        check("t5 busy mid", busy, 1);
        do_clear();
        sb.delete();
        check_all_zero("t5 abort");
        do_enter(1, 4'd8);
        check("t5 stb+enter count", count, 0);
        check("t5 stb+enter busy", busy, 1);
        wait_done("t5");

        do_clear();
        strobe(4'd1, 0); strobe(4'd2, 0);
        do_enter(0, 4'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("t6 async reset");
        sb.delete();
        #2;
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        strobe(4'd4, 0); strobe(4'd2, 0);
        do_enter(0, 4'h0);
        wait_done("t6");
        check("t6 bin_out", bin_out, 42);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(2) == 0) do_clear();
            n = $urandom_range(6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(9) == 0) begin
                    strobe(4'(10 + $urandom_range(5)), 1);
                end else begin
                    strobe(4'($urandom_range(9)), 0);
                end
            end
            if (m_done) begin
                enter = 1'b1;
                @(posedge clk);
                #1;
                enter = 1'b0;
                check("rand enter ignored", busy, 0);
                do_clear();
            end
            do_enter(0, 4'h0);
            wait_done("rand");
        end

        @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_digit_accumulator.md
Name: bcd_digit_accumulator

Overview:
- Downstream consumer of the BCD validity filter.
- Collects filtered BCD digits one at a time into a DIGITS-wide packed BCD register, MSD first.
- On an enter command, converts the collected number to binary iteratively (one digit per clock).
- Latches sticky error and overflow flags for the front panel and control logic.

Parameters:
- DIGITS, 4, number of BCD digits held (>=1).
- BIN_W, 14, binary result width; must satisfy 10^DIGITS - 1 < 2^BIN_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- digit_in  in  4  filtered BCD digit from the validity filter.
- digit_err  in  1  filter error flag; 1 marks digit_in as invalid (>9).
- digit_stb  in  1  single-cycle strobe, digit_in/digit_err valid.
- enter  in  1  single-cycle command: start conversion.
- clear  in  1  single-cycle command: discard entry and flags.
- bcd_out  out  4*DIGITS  packed BCD entry, MSD in top nibble.
- count  out  $clog2(DIGITS+1)  number of digits accepted.
- bin_out  out  BIN_W  binary value of the entry.
- bin_valid  out  1  bin_out holds the result of the last conversion.
- busy  out  1  conversion in progress.
- err_flag  out  1  sticky: an invalid digit was strobed.
- overflow  out  1  sticky: a digit arrived while DIGITS were already held.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0.
- States: IDLE (collecting), CONVERT, DONE.
- Priority at any edge: reset > clear > enter > digit_stb.
- clear, any state: next edge → IDLE; bcd_out, count, bin_out, bin_valid, err_flag, overflow all 0.
- IDLE, digit_stb with digit_err=1:
  - err_flag←1.
  - Digit dropped; bcd_out and count unchanged.
- IDLE, digit_stb with digit_err=0, count<DIGITS:
  - bcd_out←{bcd_out[4*DIGITS-5:0], digit_in}.
  - count←count+1.
- IDLE, digit_stb with digit_err=0, count==DIGITS:
  - overflow←1.
  - Digit dropped; no wrap-around or shift.
- IDLE, enter:
  - → CONVERT; busy←1.
  - Work register←bcd_out; accumulator←0; step←0.
  - A digit_stb in the same cycle is ignored.
- CONVERT: each edge processes the next nibble, MSD first:
  - acc←acc*10 + nibble, where acc*10 is computed as (acc<<3)+(acc<<1), truncated to BIN_W (no truncation occurs when the BIN_W rule holds).
  - Exactly DIGITS steps; leading zero nibbles are harmless.
  - At step DIGITS-1: bin_out←final acc, bin_valid←1, busy←0, → DONE.
  - Net latency: bin_valid visible after DIGITS rising edges following the edge that samples enter.
- CONVERT, inputs: digit_stb and enter ignored (no flag change). clear aborts per the clear rule.
- DONE:
  - bcd_out, count, bin_out and bin_valid hold.
  - enter ignored.
  - digit_stb with digit_err=0 starts a new entry in one edge: bcd_out←{0…, digit_in}, count←1, bin_valid←0, bin_out←0, → IDLE.
  - digit_stb with digit_err=1 sets err_flag only; state stays DONE.
- enter with count==0 is legal: converts to bin_out=0 with bin_valid=1.
- err_flag and overflow clear only on clear or reset; they do not block entry or conversion.
- All outputs registered; no combinational input→output paths.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, CONVERT, DONE);
  - BCD_MAX=9;
  - function bin_width(digits) returning the minimum BIN_W.
- One sub-module: bcd_mac_step, combinational acc*10+digit.
  - Parameter BIN_W.
  - Ports acc_in, digit, acc_out.

Test Plan:
- Strobe valid digits 1,2,3,4, then enter → bcd_out=16'h1234, count=4, busy high for 4 cycles, then bin_out=1234 (14'h04D2), bin_valid=1.
- Strobe 0xB with digit_err=1, then 7 valid, then enter → err_flag=1, count=1, bcd_out=16'h0007, bin_out=7.
- Strobe 9,9,9,9,5 → overflow=1 on the fifth digit, bcd_out=16'h9999; enter → bin_out=9999.
- Enter with no digits → bin_valid=1, bin_out=0; in DONE, strobe digit 3 → bin_valid=0, count=1, bcd_out=16'h0003.
- Strobe 5,6, enter, assert clear on the second CONVERT cycle → next edge IDLE, busy=0, all outputs 0; digit_stb and enter in the same cycle in IDLE → conversion starts and count is unchanged.
- Assert reset asynchronously mid-CONVERT (between clock edges) → all outputs 0 before the next edge; after release, digits 4,2 then enter → bin_out=42.
